// File: rtl/sid_defs.sv
// Shared constants for the multiplier-sharing block: operand/product widths,
// default requester count, multiplier latency, and requester-id width helper.
package sid_defs;
    localparam int MUL_LAT_DEF = 2;
    localparam int NREQ_DEF    = 3;
    localparam int A_W         = 32;
    localparam int B_W         = 16;
    localparam int P_W         = 32;
    localparam int FRAC_W      = 16;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mult32x16.sv
// Two-stage signed 32 x unsigned 16 multiplier; product is scaled down by 16
// fractional bits and truncated to 32 bits. The output register holds between products.
module mult32x16
    import sid_defs::*;
(
    input  logic           clk,
    input  logic           iRstN,
    input  logic           iEn,
    input  logic [A_W-1:0] iA,
    input  logic [B_W-1:0] iB,
    output logic [P_W-1:0] oP
);
    localparam int FULL_W = A_W + B_W + 1;

    logic              en_q, en_d;
    logic [A_W-1:0]    a_q, a_d;
    logic [B_W-1:0]    b_q, b_d;
    logic [P_W-1:0]    p_q, p_d;
    logic [FULL_W-1:0] full;
    logic              unused_hi;
    logic [FRAC_W-1:0] unused_lo;
    logic [P_W-1:0]    p_mul;

    always_comb begin
        en_d = iEn;
        a_d  = iEn ? iA : a_q;
        b_d  = iEn ? iB : b_q;
        // B is zero-extended so it always counts as a positive coefficient
        full = $signed({{(B_W + 1){a_q[A_W-1]}}, a_q}) * $signed({{A_W{1'b0}}, 1'b0, b_q});
        {unused_hi, p_mul, unused_lo} = full;
        p_d  = en_q ? p_mul : p_q;
    end

    always_ff @(posedge clk) begin
        if (!iRstN) begin
            en_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            p_q  <= '0;
        end else begin
            en_q <= en_d;
            a_q  <= a_d;
            b_q  <= b_d;
            p_q  <= p_d;
        end
    end

    assign oP = p_q;
endmodule

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: searches requests upward from the pointer with wrap
// and returns a one-hot grant plus the winner's index.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          any
);
    always_comb begin : search
        int idx;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any && req[idx]) begin
                any         = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_id      = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/mul_arbiter.sv
// Shares one mult32x16 between NREQ requesters: round-robin grant with optional
// lock, operand mux into the multiplier, and an id tag pipe aligned to its latency.
module mul_arbiter
    import sid_defs::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic              clk,
    input  logic              iRstN,
    input  logic [NREQ-1:0]   iReq,
    input  logic [NREQ-1:0]   iLock,
    input  logic [NREQ*32-1:0] iA,
    input  logic [NREQ*16-1:0] iB,
    output logic [NREQ-1:0]   oGnt,
    output logic [NREQ-1:0]   oValid,
    output logic [31:0]       oOut
);
    localparam int IW = id_w(NREQ);

    logic [A_W-1:0] a_arr [NREQ];
    logic [B_W-1:0] b_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = iA[A_W*gi +: A_W];
            assign b_arr[gi] = iB[B_W*gi +: B_W];
        end
    endgenerate

    logic [IW-1:0]   ptr_q, ptr_d;
    logic            owner_vld_q, owner_vld_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            tag_vld_q [MUL_LAT];
    logic            tag_vld_d [MUL_LAT];
    logic [IW-1:0]   tag_id_q  [MUL_LAT];
    logic [IW-1:0]   tag_id_d  [MUL_LAT];

    logic [NREQ-1:0] rr_gnt;
    logic [IW-1:0]   rr_id;
    logic            rr_any;
    logic            lock_hit;
    logic            issue;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_id;
    logic [A_W-1:0]  mux_a;
    logic [B_W-1:0]  mux_b;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .req    (iReq),
        .ptr    (ptr_q),
        .gnt    (rr_gnt),
        .gnt_id (rr_id),
        .any    (rr_any)
    );

    always_comb begin
        lock_hit = owner_vld_q && iReq[owner_q] && iLock[owner_q];
        gnt      = '0;
        gnt_id   = owner_q;
        issue    = 1'b0;
        // Grants are suppressed while reset is asserted so nothing is issued
        if (iRstN) begin
            if (lock_hit) begin
                gnt[owner_q] = 1'b1;
                issue        = 1'b1;
            end else if (rr_any) begin
                gnt    = rr_gnt;
                gnt_id = rr_id;
                issue  = 1'b1;
            end
        end

        mux_a = a_arr[gnt_id];
        mux_b = b_arr[gnt_id];

        ptr_d       = ptr_q;
        owner_d     = owner_q;
        owner_vld_d = 1'b0;
        if (issue) begin
            ptr_d       = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);
            owner_d     = gnt_id;
            owner_vld_d = iLock[gnt_id];
        end

        tag_vld_d[0] = issue;
        tag_id_d[0]  = gnt_id;
        for (int i = 1; i < MUL_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!iRstN) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_id_q[i]  <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_d[i];
                tag_id_q[i]  <= tag_id_d[i];
            end
        end
    end

    always_comb begin
        oValid = '0;
        if (tag_vld_q[MUL_LAT-1]) begin
            oValid[tag_id_q[MUL_LAT-1]] = 1'b1;
        end
    end

    assign oGnt = gnt;

    mult32x16 u_mul (
        .clk   (clk),
        .iRstN (iRstN),
        .iEn   (issue),
        .iA    (mux_a),
        .iB    (mux_b),
        .oP    (oOut)
    );
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed-vector bench for mul_arbiter: each row drives one cycle and carries the
// hand-computed grant and product; a two-deep expected pipe checks oValid/oOut.
module tb_mul_arbiter;
    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [95:0] a_bus;
    logic [47:0] b_bus;
    logic [2:0]  gnt;
    logic [2:0]  vld;
    logic [31:0] out;

    int total = 0;
    int bad   = 0;

    mul_arbiter #(
        .NREQ    (3),
        .MUL_LAT (2)
    ) dut (
        .clk    (clk),
        .iRstN  (rst_n),
        .iReq   (req),
        .iLock  (lock),
        .iA     (a_bus),
        .iB     (b_bus),
        .oGnt   (gnt),
        .oValid (vld),
        .oOut   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit [2:0]  req;
        bit [2:0]  lock;
        int        gid;
        bit [31:0] a;
        bit [15:0] b;
        bit [31:0] prod;
    } row_t;

    row_t rows[$];

    task automatic add_row(input bit rst, input bit [2:0] rq, input bit [2:0] lk, input int gid,
                           input bit [31:0] a, input bit [15:0] b, input bit [31:0] prod);
        row_t r;
        r.rst = rst; r.req = rq; r.lock = lk; r.gid = gid;
        r.a = a; r.b = b; r.prod = prod;
        rows.push_back(r);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bit        known;
        bit        s0v, s1v;
        int        s0id, s1id;
        bit [31:0] s0p, s1p, last;
        bit [2:0]  exp_gnt, exp_vld;
        bit [31:0] exp_out;

        // reset held two cycles with all requesting
        add_row(1, 3'b111, 3'b000, -1, 32'h0, 16'h0, 32'h0);
        add_row(1, 3'b111, 3'b000, -1, 32'h0, 16'h0, 32'h0);
        // round robin, first grant after release is req0
        add_row(0, 3'b111, 3'b000,  0, 32'h0002_0000, 16'h0003, 32'h0000_0006);
        add_row(0, 3'b111, 3'b000,  1, 32'h0001_0000, 16'h8000, 32'h0000_8000);
        add_row(0, 3'b111, 3'b000,  2, 32'hFFFF_0000, 16'h0010, 32'hFFFF_FFF0);
        add_row(0, 3'b111, 3'b000,  0, 32'h0000_0100, 16'h0100, 32'h0000_0001);
        add_row(0, 3'b000, 3'b000, -1, 32'h0, 16'h0, 32'h0);
        add_row(0, 3'b000, 3'b000, -1, 32'h0, 16'h0, 32'h0);
        add_row(0, 3'b000, 3'b000, -1, 32'h0, 16'h0, 32'h0);
        // single request from req1
        add_row(0, 3'b010, 3'b000,  1, 32'h0001_0000, 16'h8000, 32'h0000_8000);
        add_row(0, 3'b000, 3'b000, -1, 32'h0, 16'h0, 32'h0);
        add_row(0, 3'b000, 3'b000, -1, 32'h0, 16'h0, 32'h0);
        // reset to bring pointer to 0, then lock burst by req0 against req2
        add_row(1, 3'b000, 3'b000, -1, 32'h0, 16'h0, 32'h0);
        add_row(0, 3'b101, 3'b001,  0, 32'h0000_1000, 16'h0010, 32'h0000_0001);
        add_row(0, 3'b101, 3'b001,  0, 32'h0003_0000, 16'h0002, 32'h0000_0006);
        add_row(0, 3'b101, 3'b001,  0, 32'hFFFE_0000, 16'h0005, 32'hFFFF_FFF6);
        add_row(0, 3'b100, 3'b000,  2, 32'h0001_0001, 16'hFFFF, 32'h0000_FFFF);
        // sign and magnitude extremes
        add_row(0, 3'b001, 3'b000,  0, 32'h8000_0000, 16'hFFFF, 32'h8000_8000);
        add_row(0, 3'b010, 3'b000,  1, 32'h7FFF_FFFF, 16'hFFFF, 32'h7FFF_7FFF);
        add_row(0, 3'b100, 3'b000,  2, 32'hFFFF_FFFF, 16'h0001, 32'hFFFF_FFFF);
        add_row(0, 3'b000, 3'b000, -1, 32'h0, 16'h0, 32'h0);
        add_row(0, 3'b000, 3'b000, -1, 32'h0, 16'h0, 32'h0);
        // reset one cycle after a grant discards it and rewinds the pointer
        add_row(0, 3'b010, 3'b000,  1, 32'h0004_0000, 16'h0004, 32'h0000_0010);
        add_row(1, 3'b000, 3'b000, -1, 32'h0, 16'h0, 32'h0);
        add_row(0, 3'b111, 3'b000,  0, 32'h0005_0000, 16'h0002, 32'h0000_000A);
        add_row(0, 3'b000, 3'b000, -1, 32'h0, 16'h0, 32'h0);
        add_row(0, 3'b000, 3'b000, -1, 32'h0, 16'h0, 32'h0);

        known = 0; s0v = 0; s1v = 0; s0id = 0; s1id = 0; s0p = '0; s1p = '0; last = '0;
        rst_n = 1'b0; req = '0; lock = '0; a_bus = '0; b_bus = '0;
        @(posedge clk);
        #1;

        for (int r = 0; r < rows.size(); r++) begin
            rst_n = !rows[r].rst;
            req   = rows[r].req;
            lock  = rows[r].lock;
            for (int k = 0; k < 3; k++) begin
                a_bus[32*k +: 32] = (k == rows[r].gid) ? rows[r].a : 32'h1357_9BDF + 32'(k);
                b_bus[16*k +: 16] = (k == rows[r].gid) ? rows[r].b : 16'h2468 + 16'(k);
            end

            @(negedge clk);
            exp_gnt = (rows[r].gid >= 0) ? (3'b001 << rows[r].gid) : 3'b000;
            exp_vld = s1v ? (3'b001 << s1id) : 3'b000;
            exp_out = s1v ? s1p : last;
            $display("row %0d rst=%0b req=%b lock=%b gnt=%b vld=%b out=%h", r, rows[r].rst,
                     req, lock, gnt, vld, out);
            chk($sformatf("r%0d gnt", r), {29'b0, gnt}, {29'b0, exp_gnt});
            if (known) begin
                chk($sformatf("r%0d vld", r), {29'b0, vld}, {29'b0, exp_vld});
                chk($sformatf("r%0d out", r), out, exp_out);
            end
            last = exp_out;

            @(posedge clk);
            if (rows[r].rst) begin
                s0v = 0; s1v = 0; last = '0; known = 1;
            end else begin
                s1v = s0v; s1id = s0id; s1p = s0p;
                s0v = (rows[r].gid >= 0); s0id = rows[r].gid; s0p = rows[r].prod;
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
